// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: NUM_CH programmable tick/toggle
// channels with shadowed divisors, plus a fixed 1-in-PIX_DIV pixel enable.
module clk_enable_gen #(
  parameter int                      NUM_CH  = 4,
  parameter int                      CNT_W   = 32,
  parameter int                      SEL_W   = 4,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {4{32'd100000}},
  parameter int                      PIX_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] tog,
  output logic [NUM_CH-1:0] div_pend,
  output logic              pix_en
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] DEF = DEF_DIV[i*CNT_W +: CNT_W];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shad;
    logic             pend;
    logic             tk;
    logic             tg;
    logic             hit;
    logic             term;

    assign hit  = div_wr && (div_sel == SEL_W'(i));
    // N=0 behaves as N=1; the guard also keeps act-1 from wrapping
    assign term = (act <= CNT_W'(1)) || (cnt == act - CNT_W'(1));

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt  <= '0;
        act  <= DEF;
        shad <= DEF;
        pend <= 1'b0;
        tk   <= 1'b0;
        tg   <= 1'b0;
      end else if (!ch_en[i]) begin
        cnt <= '0;
        tk  <= 1'b0;
        if (hit) begin
          shad <= div_data;
          pend <= 1'b1;
        end else if (pend) begin
          act  <= shad;
          pend <= 1'b0;
        end
      end else if (term) begin
        cnt <= '0;
        tk  <= 1'b1;
        tg  <= ~tg;
        if (hit) begin
          act  <= div_data;
          shad <= div_data;
          pend <= 1'b0;
        end else if (pend) begin
          act  <= shad;
          pend <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
        tk  <= 1'b0;
        if (hit) begin
          shad <= div_data;
          pend <= 1'b1;
        end
      end
    end

    assign tick[i]     = tk;
    assign tog[i]      = tg;
    assign div_pend[i] = pend;
  end

  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);

  logic [PW-1:0] pixcnt;

  always_ff @(posedge clk) begin
    if (rst || pixcnt == PIX_LAST) begin
      pixcnt <= '0;
    end else begin
      pixcnt <= pixcnt + PW'(1);
    end
  end

  assign pix_en = (pixcnt == '0);

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: per-cycle expected vectors
// {tick,tog,div_pend,pix_en} are queued with the stimulus and popped after each edge.
module tb_clk_enable_gen;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int SEL_W   = 4;
  localparam int PIX_DIV = 4;
  localparam logic [NUM_CH*CNT_W-1:0] DEF = {8'd7, 8'd6, 8'd2, 8'd5};

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] tog;
  logic [NUM_CH-1:0] div_pend;
  logic              pix_en;

  typedef struct {
    int          c;
    logic [12:0] v;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   ns[4]   = '{5, 2, 6, 7};

  clk_enable_gen #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .SEL_W  (SEL_W),
    .DEF_DIV(DEF),
    .PIX_DIV(PIX_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_data(div_data),
    .tick    (tick),
    .tog     (tog),
    .div_pend(div_pend),
    .pix_en  (pix_en)
  );

  always #5 clk = ~clk;

  // Default-divisor pattern counted from reset release (c >= 1)
  function automatic logic [12:0] def_vec(int c, logic [3:0] pend);
    logic [3:0] t;
    logic [3:0] g;
    for (int i = 0; i < 4; i++) begin
      t[i] = (c % ns[i]) == 0;
      g[i] = ((c / ns[i]) % 2) == 1;
    end
    return {t, g, pend, (c % PIX_DIV) == 0};
  endfunction

  function automatic logic [12:0] mk(logic [3:0] t, logic [3:0] g,
                                     logic [3:0] p, int c);
    return {t, g, p, (c % PIX_DIV) == 0};
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    ch_en    = '0;
    div_wr   = 1'b0;
    div_sel  = '0;
    div_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [12:0] got;
    rst      = 1'b1;
    ch_en    = 4'hF;
    div_wr   = 1'b1;
    div_sel  = 4'd0;
    div_data = 8'd3;
    for (int k = 0; k < 2; k++) begin
      q.push_back('{0, 13'h0001});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL reset k=%0d got=%h want=%h", k, got, e.v);
      end
    end
    rst    = 1'b0;
    div_wr = 1'b0;
    ch_en  = 4'h1;
    for (int c = 1; c <= 6; c++) begin
      q.push_back('{c, mk({3'b0, c == 5}, {3'b0, c >= 5}, 4'h0, c)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL reset_wr c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
  endtask

  task automatic test_default();
    exp_t        e;
    logic [12:0] got;
    do_reset();
    ch_en = 4'hF;
    for (int c = 1; c <= 30; c++) begin
      q.push_back('{c, def_vec(c, 4'h0)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL default c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
  endtask

  task automatic test_div_zero_one();
    exp_t        e;
    logic [12:0] got;
    logic        t;
    logic        g;
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      div_wr   = (c == 1) || (c == 11);
      div_sel  = 4'd1;
      div_data = (c == 1) ? 8'd0 : 8'd1;
      ch_en    = (c >= 3) ? 4'b0010 : 4'b0000;
      t = c >= 3;
      g = (c >= 3) && ((c - 2) % 2 == 1);
      q.push_back('{c, mk({2'b0, t, 1'b0}, {2'b0, g, 1'b0},
                          (c == 1) ? 4'b0010 : 4'b0000, c)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL div01 c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_mid_write();
    exp_t        e;
    logic [12:0] got;
    int          nt;
    logic        t;
    do_reset();
    ch_en = 4'h1;
    for (int c = 1; c <= 16; c++) begin
      div_wr   = (c == 2);
      div_sel  = 4'd0;
      div_data = 8'd3;
      t  = (c == 5) || (c > 5 && (c - 5) % 3 == 0);
      nt = (c < 5) ? 0 : 1 + (c - 5) / 3;
      q.push_back('{c, mk({3'b0, t}, {3'b0, nt % 2 == 1},
                          {3'b0, c >= 2 && c < 5}, c)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL mid_write c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_tc_write();
    exp_t        e;
    logic [12:0] got;
    int          nt;
    logic        t;
    do_reset();
    ch_en = 4'h1;
    for (int c = 1; c <= 18; c++) begin
      div_wr   = (c == 5) || (c == 7) || (c == 10);
      div_sel  = (c == 5) ? 4'd0 : (c == 7) ? 4'd4 : 4'd15;
      div_data = (c == 5) ? 8'd4 : (c == 7) ? 8'd2 : 8'd1;
      t  = (c >= 5) && ((c - 5) % 4 == 0);
      nt = (c < 5) ? 0 : 1 + (c - 5) / 4;
      q.push_back('{c, mk({3'b0, t}, {3'b0, nt % 2 == 1}, 4'h0, c)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL tc_write c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_disable();
    exp_t        e;
    logic [12:0] got;
    logic        t;
    logic        g;
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      ch_en = (c >= 8 && c <= 14) ? 4'h0 : 4'h1;
      t = (c == 5) || (c == 19) || (c == 24);
      g = (c >= 5 && c < 19) || (c >= 24);
      q.push_back('{c, mk({3'b0, t}, {3'b0, g}, 4'h0, c)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL disable c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
  endtask

  task automatic test_max_div();
    exp_t        e;
    logic [12:0] got;
    int          nt;
    logic        t;
    do_reset();
    for (int c = 1; c <= 515; c++) begin
      div_wr   = (c == 1);
      div_sel  = 4'd3;
      div_data = 8'd255;
      ch_en    = (c >= 3) ? 4'b1000 : 4'b0000;
      t  = (c >= 3) && ((c - 2) % 255 == 0);
      nt = (c >= 3) ? (c - 2) / 255 : 0;
      q.push_back('{c, mk({t, 3'b0}, {nt % 2 == 1, 3'b0},
                          {c == 1, 3'b0}, c)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL max_div c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    logic [12:0] got;
    do_reset();
    ch_en = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      div_wr   = (c == 2);
      div_sel  = 4'd0;
      div_data = 8'd3;
      q.push_back('{c, def_vec(c, (c >= 2) ? 4'h1 : 4'h0)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL pre_rst c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
    rst      = 1'b1;
    div_wr   = 1'b1;
    div_sel  = 4'd1;
    div_data = 8'd9;
    q.push_back('{0, 13'h0001});
    @(posedge clk);
    #1;
    e   = q.pop_front();
    got = {tick, tog, div_pend, pix_en};
    vectors++;
    if (got !== e.v) begin
      errors++;
      $display("FAIL mid_rst got=%h want=%h", got, e.v);
    end
    rst    = 1'b0;
    div_wr = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      q.push_back('{c, def_vec(c, 4'h0)});
      @(posedge clk);
      #1;
      e   = q.pop_front();
      got = {tick, tog, div_pend, pix_en};
      vectors++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL post_rst c=%0d got=%h want=%h", e.c, got, e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    ch_en    = '0;
    div_wr   = 1'b0;
    div_sel  = '0;
    div_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_default();
    test_div_zero_one();
    test_mid_write();
    test_tc_write();
    test_disable();
    test_max_div();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
